audio_sample_decimator: RTL and testbench

- Parametrised audio output stage between audio_processing_unit's 9-bit o_sample stream and the host/DAC sink; replaces bare bit-slice truncation of the APU sample.
- Box-filter decimates by 2^DECIM_LOG2, converts IN_WIDTH to OUT_WIDTH with round-half-up and saturation, and buffers results in a FIFO drained over a valid/ready handshake.
- Reports FIFO fill level and a sticky overflow flag for the simulation host.

---
 rtl/audio_sample_decimator_pkg.sv | 16 +
 rtl/audio_sample_decimator_sync_fifo.sv | 77 +++++++
 rtl/audio_sample_decimator.sv | 141 ++++++++++++++
 tb/tb_audio_sample_decimator.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/audio_sample_decimator_pkg.sv
// Shared audio constants and elaboration helpers for the APU output stage.
package audio_sample_decimator_pkg;

  localparam int APU_SAMPLE_WIDTH = 9;
  localparam int MAX_OUT_WIDTH    = 16;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((32'sd1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/audio_sample_decimator_sync_fifo.sv
// First-word fall-through FIFO with registered head, valid and level outputs.
module sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_push,
  input  logic [WIDTH-1:0]      i_data,
  input  logic                  i_pop,
  output logic                  o_valid,
  output logic [WIDTH-1:0]      o_data,
  output logic                  o_full,
  output logic [DEPTH_LOG2:0]   o_level
);

  localparam int PW = DEPTH_LOG2 + 1;

  logic [WIDTH-1:0] mem_r [2**DEPTH_LOG2];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [PW-1:0]    level_r;
  logic             valid_r;
  logic [WIDTH-1:0] data_r;

  logic             pop_s;
  logic             push_s;
  logic [PW-1:0]    wr_next_s;
  logic [PW-1:0]    rd_next_s;
  logic [PW-1:0]    level_next_s;

  assign o_full  = level_r[DEPTH_LOG2];
  assign o_valid = valid_r;
  assign o_data  = data_r;
  assign o_level = level_r;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  always_comb begin
    pop_s  = i_pop & valid_r;
    push_s = i_push & (~o_full | pop_s);
    wr_next_s    = wr_ptr_r + {{DEPTH_LOG2{1'b0}}, push_s};
    rd_next_s    = rd_ptr_r + {{DEPTH_LOG2{1'b0}}, pop_s};
    level_next_s = wr_next_s - rd_next_s;
  end

  always_ff @(posedge i_clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r[DEPTH_LOG2-1:0]] <= i_data;
    end
  end

  // Head register looks one cycle ahead so it is valid together with o_valid.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
      valid_r  <= 1'b0;
      data_r   <= '0;
    end else begin
      wr_ptr_r <= wr_next_s;
      rd_ptr_r <= rd_next_s;
      level_r  <= level_next_s;
      valid_r  <= (level_next_s != '0);
      if (level_next_s != '0) begin
        if (push_s && (wr_ptr_r[DEPTH_LOG2-1:0] == rd_next_s[DEPTH_LOG2-1:0])) begin
          data_r <= i_data;
        end else begin
          data_r <= mem_r[rd_next_s[DEPTH_LOG2-1:0]];
        end
      end else begin
        data_r <= data_r;
      end
    end
  end

endmodule

// File: rtl/audio_sample_decimator.sv
// Box-filter decimator, rounding/saturating width converter and output FIFO
// between the APU sample stream and the host/DAC sink.
module audio_sample_decimator
  import audio_sample_decimator_pkg::*;
#(
  parameter int IN_WIDTH        = APU_SAMPLE_WIDTH,
  parameter int OUT_WIDTH       = 8,
  parameter int DECIM_LOG2      = 2,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_enable,
  input  logic                       i_sample_valid,
  input  logic [IN_WIDTH-1:0]        i_sample,
  output logic                       o_valid,
  output logic [OUT_WIDTH-1:0]       o_sample,
  input  logic                       i_ready,
  output logic [FIFO_DEPTH_LOG2:0]   o_level,
  output logic                       o_overflow,
  input  logic                       i_clear_overflow
);

  localparam int ACC_W   = IN_WIDTH + DECIM_LOG2;
  localparam int PHASE_W = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
  localparam logic [PHASE_W-1:0] PHASE_MAX = PHASE_W'((2 ** DECIM_LOG2) - 1);

  logic [ACC_W-1:0]     acc_r;
  logic [PHASE_W-1:0]   phase_r;
  logic                 stage_valid_r;
  logic [OUT_WIDTH-1:0] stage_data_r;
  logic                 overflow_r;

  logic [ACC_W-1:0]     sum_s;
  logic [IN_WIDTH-1:0]  avg_s;
  logic [OUT_WIDTH-1:0] conv_s;
  logic                 strobe_s;
  logic                 last_s;
  logic                 fifo_full_s;
  logic                 drop_s;

  always_comb begin
    strobe_s = i_sample_valid & i_enable;
    last_s   = (phase_r == PHASE_MAX);
    sum_s    = acc_r + ACC_W'(i_sample);
    avg_s    = IN_WIDTH'(sum_s >> DECIM_LOG2);
  end

  generate
    if (OUT_WIDTH < IN_WIDTH) begin : g_narrow
      localparam int SH = IN_WIDTH - OUT_WIDTH;
      localparam logic [IN_WIDTH:0] HALF_LSB = (IN_WIDTH + 1)'(2 ** (SH - 1));
      logic [IN_WIDTH:0] rnd_s;
      // Round half up; a carry into bit IN_WIDTH means the result would wrap.
      always_comb begin
        rnd_s = {1'b0, avg_s} + HALF_LSB;
        if (rnd_s[IN_WIDTH]) begin
          conv_s = '1;
        end else begin
          conv_s = OUT_WIDTH'(rnd_s >> SH);
        end
      end
    end else if (OUT_WIDTH == IN_WIDTH) begin : g_pass
      always_comb begin
        conv_s = avg_s;
      end
    end else begin : g_wide
      localparam int REPS = (OUT_WIDTH / IN_WIDTH) + 1;
      logic [REPS*IN_WIDTH-1:0] rep_s;
      // Bit replication keeps full scale at full scale when widening.
      always_comb begin
        rep_s  = {REPS{avg_s}};
        conv_s = OUT_WIDTH'(rep_s >> (REPS * IN_WIDTH - OUT_WIDTH));
      end
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc_r         <= '0;
      phase_r       <= '0;
      stage_valid_r <= 1'b0;
      stage_data_r  <= '0;
    end else begin
      if (!i_enable) begin
        acc_r   <= '0;
        phase_r <= '0;
      end else if (i_sample_valid) begin
        if (last_s) begin
          acc_r   <= '0;
          phase_r <= '0;
        end else begin
          acc_r   <= sum_s;
          phase_r <= phase_r + PHASE_W'(1);
        end
      end else begin
        acc_r   <= acc_r;
        phase_r <= phase_r;
      end
      if (strobe_s && last_s) begin
        stage_valid_r <= 1'b1;
        stage_data_r  <= conv_s;
      end else begin
        stage_valid_r <= 1'b0;
        stage_data_r  <= stage_data_r;
      end
    end
  end

  sync_fifo #(
    .WIDTH      (OUT_WIDTH),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (stage_valid_r),
    .i_data  (stage_data_r),
    .i_pop   (i_ready),
    .o_valid (o_valid),
    .o_data  (o_sample),
    .o_full  (fifo_full_s),
    .o_level (o_level)
  );

  assign drop_s     = stage_valid_r & fifo_full_s & ~(o_valid & i_ready);
  assign o_overflow = overflow_r;

  // A drop in the same cycle as a clear request wins.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      overflow_r <= 1'b0;
    end else if (drop_s) begin
      overflow_r <= 1'b1;
    end else if (i_clear_overflow) begin
      overflow_r <= 1'b0;
    end else begin
      overflow_r <= overflow_r;
    end
  end

endmodule

// File: tb/tb_audio_sample_decimator.sv
// Directed self-checking bench for audio_sample_decimator (default, bypass and widening builds).
module tb_audio_sample_decimator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       enable;
  logic       sample_valid;
  logic [8:0] sample;
  logic       ready;
  logic       clear_ovf;
  logic       valid;
  logic [7:0] osample;
  logic [4:0] level;
  logic       overflow;

  logic        byp_sv;
  logic        byp_valid;
  logic [7:0]  byp_sample;
  logic [4:0]  byp_level;
  logic        byp_ovf;
  logic        wide_sv;
  logic        wide_valid;
  logic [11:0] wide_sample;
  logic [4:0]  wide_level;
  logic        wide_ovf;

  int checks_total  = 0;
  int checks_passed = 0;

  audio_sample_decimator u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_sample_valid(sample_valid),
    .i_sample(sample), .o_valid(valid), .o_sample(osample), .i_ready(ready),
    .o_level(level), .o_overflow(overflow), .i_clear_overflow(clear_ovf)
  );

  audio_sample_decimator #(.OUT_WIDTH(8), .DECIM_LOG2(0)) u_byp (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(1'b1), .i_sample_valid(byp_sv),
    .i_sample(sample), .o_valid(byp_valid), .o_sample(byp_sample), .i_ready(1'b1),
    .o_level(byp_level), .o_overflow(byp_ovf), .i_clear_overflow(1'b0)
  );

  audio_sample_decimator #(.OUT_WIDTH(12), .DECIM_LOG2(0)) u_wide (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(1'b1), .i_sample_valid(wide_sv),
    .i_sample(sample), .o_valid(wide_valid), .o_sample(wide_sample), .i_ready(1'b1),
    .o_level(wide_level), .o_overflow(wide_ovf), .i_clear_overflow(1'b0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    assert (obs === exp) checks_passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [8:0] v);
    sample       = v;
    sample_valid = 1'b1;
    tick(1);
    sample_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b1; sample_valid = 1'b0; sample = 9'd0;
    ready = 1'b1; clear_ovf = 1'b0; byp_sv = 1'b0; wide_sv = 1'b0;
    tick(2);
    check("reset_valid", 32'(valid), 32'd0);
    check("reset_sample", 32'(osample), 32'd0);
    check("reset_level", 32'(level), 32'd0);
    check("reset_overflow", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    tick(1);

    // average 101 -> 51, o_valid appears two cycles after the last strobe
    strobe(9'd100); strobe(9'd101); strobe(9'd102); strobe(9'd103);
    check("lat_valid_n1", 32'(valid), 32'd0);
    tick(1);
    check("lat_valid_n2", 32'(valid), 32'd1);
    check("avg_sample", 32'(osample), 32'd51);
    tick(1);
    check("pulse_end", 32'(valid), 32'd0);
    check("empty_hold", 32'(osample), 32'd51);

    // saturation
    ready = 1'b0;
    repeat (4) strobe(9'd511);
    tick(1);
    check("sat_sample", 32'(osample), 32'd255);
    check("sat_level", 32'(level), 32'd1);
    ready = 1'b1;
    tick(1);
    check("sat_drained", 32'(level), 32'd0);

    // bypass and widening builds
    sample = 9'd300; byp_sv = 1'b1; tick(1); byp_sv = 1'b0;
    check("byp_lat", 32'(byp_valid), 32'd0);
    tick(1);
    check("byp_valid", 32'(byp_valid), 32'd1);
    check("byp_sample", 32'(byp_sample), 32'd150);
    sample = 9'd511; wide_sv = 1'b1; tick(1); wide_sv = 1'b0;
    tick(1);
    check("wide_full", 32'(wide_sample), 32'd4095);
    sample = 9'd256; wide_sv = 1'b1; tick(1); wide_sv = 1'b0;
    tick(1);
    check("wide_256", 32'(wide_sample), 32'd2052);

    // fill the FIFO under backpressure: results 5,10,...,85
    ready = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      repeat (4) strobe(9'(10 * k));
    end
    tick(1);
    check("ovf_level", 32'(level), 32'd16);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_head", 32'(osample), 32'd5);
    clear_ovf = 1'b1; tick(1); clear_ovf = 1'b0;
    check("ovf_clear", 32'(overflow), 32'd0);
    repeat (4) strobe(9'd200);
    ready = 1'b1; tick(1); ready = 1'b0;
    check("pp_level", 32'(level), 32'd16);
    check("pp_overflow", 32'(overflow), 32'd0);
    check("pp_head", 32'(osample), 32'd10);
    ready = 1'b1;
    tick(16);
    check("drain_level", 32'(level), 32'd0);
    check("drain_valid", 32'(valid), 32'd0);
    check("drain_last", 32'(osample), 32'd100);

    // reset discards a partial sum
    ready = 1'b0;
    strobe(9'd200); strobe(9'd200);
    rst_n = 1'b0; tick(1); rst_n = 1'b1; tick(1);
    repeat (4) strobe(9'd8);
    tick(1);
    check("rst_level", 32'(level), 32'd1);
    check("rst_sample", 32'(osample), 32'd4);
    ready = 1'b1; tick(1);
    check("rst_drained", 32'(level), 32'd0);

    // strobes while disabled are ignored; head stable under backpressure
    ready = 1'b0;
    enable = 1'b0;
    strobe(9'd77); strobe(9'd77);
    enable = 1'b1;
    repeat (4) strobe(9'd50);
    tick(1);
    check("en_level", 32'(level), 32'd1);
    check("en_sample", 32'(osample), 32'd25);
    tick(3);
    check("bp_valid", 32'(valid), 32'd1);
    check("bp_sample", 32'(osample), 32'd25);
    check("bp_level", 32'(level), 32'd1);
    ready = 1'b1; tick(1);
    ready = 1'b0; tick(2);
    check("en_single", 32'(level), 32'd0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
